// File: rtl/axi_spi_pkg.sv
// rtl/axi_spi_pkg.sv - shared AXI constants and sequencer state encodings
package axi_spi_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE    = 3'd0;
    localparam seq_state_t ST_WR_REQ  = 3'd1;
    localparam seq_state_t ST_WR_RESP = 3'd2;
    localparam seq_state_t ST_RD_REQ  = 3'd3;
    localparam seq_state_t ST_RD_RESP = 3'd4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Sideband tie-offs applied by the parent to the single-beat port.
    localparam logic [7:0] AXI_LEN_TIE    = 8'd0;
    localparam logic [2:0] AXI_PROT_TIE   = 3'd0;
    localparam logic [3:0] AXI_CACHE_TIE  = 4'd0;
    localparam logic [3:0] AXI_QOS_TIE    = 4'd0;
    localparam logic [3:0] AXI_REGION_TIE = 4'd0;
    localparam logic       AXI_LOCK_TIE   = 1'b0;

    function automatic logic [2:0] axi_size(input int data_width);
        return (data_width == 64) ? 3'd3 : 3'd2;
    endfunction

endpackage

// File: rtl/axi_spi_txn_sequencer_if.sv
// rtl/axi_spi_txn_sequencer_if.sv - single-beat AXI4 subset between the sequencer and the SoC port
interface axi_spi_txn_sequencer_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 16
);
    logic                          aw_valid;
    logic                          aw_ready;
    logic [AXI_ADDR_WIDTH-1:0]     aw_addr;
    logic [AXI_ID_WIDTH-1:0]       aw_id;
    logic [2:0]                    aw_size;
    logic                          w_valid;
    logic                          w_ready;
    logic [AXI_DATA_WIDTH-1:0]     w_data;
    logic [AXI_DATA_WIDTH/8-1:0]   w_strb;
    logic                          w_last;
    logic                          b_valid;
    logic [1:0]                    b_resp;
    logic                          b_ready;
    logic                          ar_valid;
    logic                          ar_ready;
    logic [AXI_ADDR_WIDTH-1:0]     ar_addr;
    logic [AXI_ID_WIDTH-1:0]       ar_id;
    logic [2:0]                    ar_size;
    logic                          r_valid;
    logic [AXI_DATA_WIDTH-1:0]     r_data;
    logic [1:0]                    r_resp;
    logic                          r_last;
    logic                          r_ready;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_size,
        output w_valid, w_data, w_strb, w_last,
        output b_ready,
        output ar_valid, ar_addr, ar_id, ar_size,
        output r_ready,
        input  aw_ready, w_ready, b_valid, b_resp,
        input  ar_ready, r_valid, r_data, r_resp, r_last
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_size,
        input  w_valid, w_data, w_strb, w_last,
        input  b_ready,
        input  ar_valid, ar_addr, ar_id, ar_size,
        input  r_ready,
        output aw_ready, w_ready, b_valid, b_resp,
        output ar_ready, r_valid, r_data, r_resp, r_last
    );
endinterface

// File: rtl/axi_spi_txn_sequencer.sv
// rtl/axi_spi_txn_sequencer.sv - one-at-a-time req/gnt to single-beat AXI4 transaction sequencer
module axi_spi_txn_sequencer
    import axi_spi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 16,
    parameter int AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    axi_spi_txn_sequencer_if.master     axi
);

    seq_state_t                  state;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] be_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic                        aw_done;
    logic                        w_done;
    logic                        rvalid_q;
    logic                        err_q;
    logic                        aw_fin;
    logic                        w_fin;
    logic                        unused_resp;

    assign axi.aw_valid = (state == ST_WR_REQ) && !aw_done;
    assign axi.aw_addr  = addr_q;
    assign axi.aw_id    = AXI_ID_WIDTH'(AXI_ID);
    assign axi.aw_size  = axi_size(AXI_DATA_WIDTH);
    assign axi.w_valid  = (state == ST_WR_REQ) && !w_done;
    assign axi.w_data   = wdata_q;
    assign axi.w_strb   = be_q;
    assign axi.w_last   = axi.w_valid;
    assign axi.b_ready  = (state == ST_WR_RESP);
    assign axi.ar_valid = (state == ST_RD_REQ);
    assign axi.ar_addr  = addr_q;
    assign axi.ar_id    = AXI_ID_WIDTH'(AXI_ID);
    assign axi.ar_size  = axi_size(AXI_DATA_WIDTH);
    assign axi.r_ready  = (state == ST_RD_RESP);

    // A handshake counts as finished if it completed earlier or completes this cycle.
    assign aw_fin = aw_done || (axi.aw_valid && axi.aw_ready);
    assign w_fin  = w_done  || (axi.w_valid  && axi.w_ready);

    // Grant is withheld in the completion cycle so the next command starts one cycle later.
    assign gnt_o    = rst_ni && (state == ST_IDLE) && !rvalid_q && req_i;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

    assign unused_resp = ^{axi.b_resp[0], axi.r_resp[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_o) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        state   <= we_i ? ST_WR_REQ : ST_RD_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_fin && w_fin) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ST_WR_RESP;
                    end else begin
                        aw_done <= aw_fin;
                        w_done  <= w_fin;
                    end
                end
                ST_WR_RESP: begin
                    if (axi.b_valid) begin
                        rvalid_q <= 1'b1;
                        err_q    <= axi.b_resp[1];
                        state    <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (axi.ar_ready) begin
                        state <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (axi.r_valid) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= axi.r_data;
                        // A single-beat read must end with r_last; anything else is a protocol error.
                        err_q    <= axi.r_resp[1] || !axi.r_last;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_spi_txn_sequencer.sv
// tb/tb_axi_spi_txn_sequencer.sv - directed self-checking bench for the AXI transaction sequencer
module tb_axi_spi_txn_sequencer;
    import axi_spi_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int IW    = 16;
    localparam int TB_ID = 16'h2A;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    be;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    int checks   = 0;
    int failures = 0;

    axi_spi_txn_sequencer_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) axi();

    axi_spi_txn_sequencer #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH  (IW),
        .AXI_ID        (TB_ID)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .gnt_o   (gnt),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .err_o   (err),
        .axi     (axi)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [63:0] d,
                           input logic [1:0] resp, input logic last, input logic exp_err);
        axi.r_data = d;
        axi.r_resp = resp;
        axi.r_last = last;
        req = 1'b1; we = 1'b0; addr = a;
        #1;
        check_eq({tag, "_gnt"}, 64'(gnt), 64'd1);
        step();
        req = 1'b0;
        check_eq({tag, "_ar_valid"}, 64'(axi.ar_valid), 64'd1);
        check_eq({tag, "_ar_addr"}, 64'(axi.ar_addr), 64'(a));
        step();
        check_eq({tag, "_r_ready"}, 64'(axi.r_ready), 64'd1);
        check_eq({tag, "_rvalid_early"}, 64'(rvalid), 64'd0);
        step();
        check_eq({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        check_eq({tag, "_rdata"}, rdata, d);
        check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
        step();
        check_eq({tag, "_rvalid_pulse"}, 64'(rvalid), 64'd0);
        check_eq({tag, "_rdata_hold"}, rdata, d);
    endtask

    initial begin
        int gnt_cnt, rv_cnt, overlap, gnt2_cyc;
        logic [63:0] first_rdata;

        rst_n = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.b_valid = 1'b0; axi.b_resp = AXI_RESP_OKAY;
        axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = AXI_RESP_OKAY; axi.r_last = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_gnt", 64'(gnt), 64'd0);
        check_eq("rst_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 64'd0);
        check_eq("rst_readies", 64'({axi.b_ready, axi.r_ready}), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("rst_rdata", rdata, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Write with every ready high
        axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.ar_ready = 1'b1;
        axi.b_valid = 1'b1; axi.b_resp = AXI_RESP_OKAY;
        req = 1'b1; we = 1'b1; addr = 32'h1000_0040; wdata = 64'hDEAD_BEEF_0123_4567; be = 8'hFF;
        #1;
        check_eq("w1_gnt", 64'(gnt), 64'd1);
        step();
        req = 1'b0;
        check_eq("w1_aw_w_valid", 64'({axi.aw_valid, axi.w_valid}), 64'b11);
        check_eq("w1_aw_addr", 64'(axi.aw_addr), 64'h1000_0040);
        check_eq("w1_w_data", axi.w_data, 64'hDEAD_BEEF_0123_4567);
        check_eq("w1_w_strb", 64'(axi.w_strb), 64'hFF);
        check_eq("w1_w_last", 64'(axi.w_last), 64'd1);
        check_eq("w1_aw_size", 64'(axi.aw_size), 64'd3);
        check_eq("w1_aw_id", 64'(axi.aw_id), 64'h2A);
        step();
        check_eq("w1_b_ready", 64'(axi.b_ready), 64'd1);
        check_eq("w1_aw_dropped", 64'(axi.aw_valid), 64'd0);
        step();
        check_eq("w1_rvalid", 64'(rvalid), 64'd1);
        check_eq("w1_err", 64'(err), 64'd0);
        step();
        check_eq("w1_rvalid_pulse", 64'(rvalid), 64'd0);

        // Write with AW ready held off for three cycles
        axi.aw_ready = 1'b0;
        req = 1'b1; we = 1'b1; addr = 32'h3000_0010; wdata = 64'h1111_2222_3333_4444; be = 8'h0F;
        #1;
        check_eq("w2_gnt", 64'(gnt), 64'd1);
        step();
        req = 1'b0;
        check_eq("w2_c1_valids", 64'({axi.aw_valid, axi.w_valid}), 64'b11);
        step();
        check_eq("w2_c2_valids", 64'({axi.aw_valid, axi.w_valid}), 64'b10);
        check_eq("w2_c2_aw_addr", 64'(axi.aw_addr), 64'h3000_0010);
        step();
        check_eq("w2_c3_valids", 64'({axi.aw_valid, axi.w_valid}), 64'b10);
        step();
        axi.aw_ready = 1'b1;
        check_eq("w2_c4_aw_valid", 64'(axi.aw_valid), 64'd1);
        check_eq("w2_c4_aw_addr", 64'(axi.aw_addr), 64'h3000_0010);
        check_eq("w2_c4_b_ready", 64'(axi.b_ready), 64'd0);
        rv_cnt = 0;
        for (int c = 5; c < 10; c++) begin
            step();
            if (c == 5) check_eq("w2_c5_b_ready", 64'(axi.b_ready), 64'd1);
            if (c == 6) check_eq("w2_c6_rvalid", 64'(rvalid), 64'd1);
            rv_cnt += int'(rvalid);
        end
        check_eq("w2_completions", 64'(rv_cnt), 64'd1);

        // Reads: slave error, then a missing r_last
        axi.b_valid = 1'b0;
        axi.r_valid = 1'b1;
        do_read("r1", 32'h2000_0008, 64'hCAFE, AXI_RESP_SLVERR, 1'b1, 1'b1);
        do_read("r2", 32'h2000_0010, 64'h1234, AXI_RESP_OKAY, 1'b0, 1'b1);

        // Back-to-back write then read with req held high
        axi.b_valid = 1'b1; axi.b_resp = AXI_RESP_OKAY;
        axi.r_data = 64'h55AA; axi.r_resp = AXI_RESP_OKAY; axi.r_last = 1'b1;
        req = 1'b1; we = 1'b1; addr = 32'h4000_0000; wdata = 64'h77; be = 8'h01;
        gnt_cnt = 0; rv_cnt = 0; overlap = 0; gnt2_cyc = -1; first_rdata = '0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) we = 1'b0;
            if (c == 5) req = 1'b0;
            #1;
            if (gnt) begin
                gnt_cnt++;
                if (gnt_cnt == 2) gnt2_cyc = c;
            end
            if (rvalid) begin
                rv_cnt++;
                if (rv_cnt == 1) first_rdata = rdata;
            end
            if (axi.aw_valid && axi.ar_valid) overlap++;
            @(posedge clk);
            #1;
        end
        check_eq("b2b_gnt_count", 64'(gnt_cnt), 64'd2);
        check_eq("b2b_second_gnt_cycle", 64'(gnt2_cyc), 64'd4);
        check_eq("b2b_completions", 64'(rv_cnt), 64'd2);
        check_eq("b2b_aw_ar_overlap", 64'(overlap), 64'd0);
        check_eq("b2b_write_keeps_rdata", first_rdata, 64'h1234);
        check_eq("b2b_read_rdata", rdata, 64'h55AA);

        // Asynchronous reset while waiting for B
        axi.b_valid = 1'b0;
        req = 1'b1; we = 1'b1; addr = 32'h5000_0000;
        #1;
        step();
        req = 1'b0;
        step();
        check_eq("rst_mid_b_ready_before", 64'(axi.b_ready), 64'd1);
        req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 64'd0);
        check_eq("rst_mid_readies", 64'({axi.b_ready, axi.r_ready}), 64'd0);
        check_eq("rst_mid_gnt", 64'(gnt), 64'd0);
        check_eq("rst_mid_rdata", rdata, 64'd0);
        #1 rst_n = 1'b1;
        #1;
        check_eq("rst_rel_gnt", 64'(gnt), 64'd1);
        req = 1'b0;
        #1;
        check_eq("rst_rel_gnt_follows", 64'(gnt), 64'd0);
        step();
        check_eq("rst_rel_idle", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_spi_txn_sequencer.md
Name: axi_spi_txn_sequencer

Overview:
- Sequences single-beat AXI4 transactions on behalf of a simple req/gnt command source, e.g. the SPI slave command decoder or a debug bridge.
- Accepts one command at a time and issues AW+W then waits for B, or issues AR then waits for R.
- Returns one completion pulse carrying read data and error status.
- Sits between the command logic and the SoC AXI master port of the SPI slave subsystem.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width. Must be 32 or 64.
- AXI_ID_WIDTH, 16, ID width.
- AXI_ID, 0, fixed ID driven on aw_id/ar_id.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_i  in  1  command request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AXI_ADDR_WIDTH  byte address
- wdata_i  in  AXI_DATA_WIDTH  write data
- be_i  in  AXI_DATA_WIDTH/8  byte enables
- gnt_o  out  1  command accepted
- rvalid_o  out  1  completion pulse
- rdata_o  out  AXI_DATA_WIDTH  read data (valid with rvalid_o on reads)
- err_o  out  1  bus error (valid with rvalid_o)
- aw_valid  out  1
- aw_ready  in  1
- aw_addr  out  AXI_ADDR_WIDTH
- aw_id  out  AXI_ID_WIDTH
- aw_size  out  3
- w_valid  out  1
- w_ready  in  1
- w_data  out  AXI_DATA_WIDTH
- w_strb  out  AXI_DATA_WIDTH/8
- w_last  out  1
- b_valid  in  1
- b_resp  in  2
- b_ready  out  1
- ar_valid  out  1
- ar_ready  in  1
- ar_addr  out  AXI_ADDR_WIDTH
- ar_id  out  AXI_ID_WIDTH
- ar_size  out  3
- r_valid  in  1
- r_data  in  AXI_DATA_WIDTH
- r_resp  in  2
- r_last  in  1
- r_ready  out  1

The remaining AXI sideband fields are tied at the parent from package constants:
- len = 0
- burst = INCR
- prot, region, lock, cache, qos, user = 0

Behaviour:
- Clocking and reset:
  - One clock, clk_i.
  - Reset rst_ni is asynchronous and active-low.
  - Reset forces state IDLE. All valid/ready outputs, gnt_o, rvalid_o and err_o go to 0. rdata_o, addr and data registers clear to 0.
  - Reset mid-transaction abandons the transaction; there is no recovery handshake.
- Constant outputs:
  - aw_size = ar_size = log2(AXI_DATA_WIDTH/8).
  - w_last = 1 whenever w_valid = 1.
  - aw_id = ar_id = AXI_ID.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - gnt_o = req_i, combinational, asserted only in IDLE.
  - On req_i, capture addr/wdata/be/we.
  - Next state is WR_REQ if we_i, else RD_REQ.
- WR_REQ:
  - aw_valid and w_valid both rise the cycle after grant.
  - Each is held stable until its own handshake; aw_done/w_done flags track completion independently. The two handshakes may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - b_ready = 1.
  - On b_valid, register err = b_resp[1], pulse rvalid_o for 1 cycle, then return to IDLE.
- RD_REQ:
  - ar_valid is held until ar_ready, then go to RD_RESP.
- RD_RESP:
  - r_ready = 1.
  - On r_valid, register rdata_o = r_data and err = r_resp[1].
  - If r_last = 0, err = 1 as well (protocol violation flagged).
  - Pulse rvalid_o, then return to IDLE.
- Completion outputs:
  - rdata_o holds its value until the next read completion.
  - On writes rdata_o is unchanged.
  - err_o is meaningful only while rvalid_o = 1.
- Latency, all readies tied high:
  - Write: gnt at cycle 0, AW/W valid at cycle 1, B at cycle 2, rvalid_o at cycle 3.
  - Read: gnt at cycle 0, AR at cycle 1, R at cycle 2, rvalid_o at cycle 3.
- Throughput and ordering:
  - One outstanding transaction. The next gnt_o is possible in the cycle after rvalid_o.
  - req_i held during a transaction is ignored until IDLE.
  - A b_valid/r_valid arriving in a state not waiting for it is not accepted, because ready stays low.

Decomposition:
- Shared package axi_spi_pkg holds:
  - State enum.
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - AXI_BURST_INCR.
  - Tie-off constants for prot/cache/qos/region.
- No sub-module; a single FSM plus capture registers.

Test Plan:
- Write 0x1000_0040, data 0xDEAD_BEEF_0123_4567, be 0xFF, all readies high -> aw_valid/w_valid at cycle 1; rvalid_o at cycle 3 with err_o = 0.
- Write with aw_ready delayed 3 cycles and w_ready immediate -> w handshakes at cycle 1, AW at cycle 4, AW/W fields stable until their handshake, exactly one write completion.
- Read 0x2000_0008, slave returns r_data 0xCAFE, r_resp = SLVERR, r_last = 1 -> rdata_o = 0xCAFE, err_o = 1, one rvalid_o pulse.
- Read with r_last = 0 and OKAY -> err_o = 1.
- Back-to-back requests with req_i held high -> gnt_o only in IDLE, two completions, no overlap of AW and AR.
- Assert rst_ni low while in WR_RESP -> all valids and readies 0 asynchronously; after release, state IDLE and gnt_o follows req_i.
